// File: rtl/bug_probe.sv
// Debug probe: snapshots a 16-bit probe word once per display frame and serves the digit picked by bugsel.
// Latency: bugsel edge to bugout is 3 mclk cycles; button press to frozen toggle is 2 + (2^DEB_BITS - 1) + 1 cycles.
// No backpressure: the debug board free-runs bugsel, and a frozen snapshot simply ignores frame boundaries.
module bug_probe #(
    parameter int DEB_BITS = 16
) (
    input  logic        mclk,
    input  logic        rst_n,
    input  logic [15:0] probe,
    input  logic [1:0]  bugsel,
    input  logic        freeze_btn,
    output logic [3:0]  bugout,
    output logic        frozen,
    output logic        frame
);

    localparam logic [0:0] LIVE = 1'b0;
    localparam logic [0:0] HELD = 1'b1;

    logic [1:0]          sel_m_q, sel_m_d;
    logic [1:0]          sel_s_q, sel_s_d;
    logic [1:0]          sel_p_q, sel_p_d;
    logic                btn_m_q, btn_m_d;
    logic                btn_s_q, btn_s_d;
    logic                stable_q, stable_d;
    logic [DEB_BITS-1:0] dcnt_q, dcnt_d;
    logic [0:0]          state_q, state_d;
    logic [15:0]         snap_q, snap_d;
    logic                frame_q, frame_d;
    logic [3:0]          bugout_q, bugout_d;

    logic                bound;
    logic                press;
    logic                load;
    logic [15:0]         nxt;

    // Synchronizers for the asynchronous board select and the raw button.
    always_comb begin
        sel_m_d = bugsel;
        sel_s_d = sel_m_q;
        sel_p_d = sel_s_q;
        btn_m_d = freeze_btn;
        btn_s_d = btn_m_q;
    end

    // Any nonzero-to-00 step of the synchronized select starts a new frame.
    always_comb begin
        bound = (sel_s_q == 2'b00) && (sel_p_q != 2'b00);
    end

    // Debounce: the level must differ from stable for a full count before it is accepted.
    always_comb begin
        stable_d = stable_q;
        dcnt_d   = dcnt_q;
        press    = 1'b0;
        if (btn_s_q == stable_q) begin
            dcnt_d = '0;
        end else if (&dcnt_q) begin
            stable_d = btn_s_q;
            dcnt_d   = '0;
            press    = btn_s_q;
        end else begin
            dcnt_d = dcnt_q + DEB_BITS'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LIVE:    if (press) state_d = HELD;
            HELD:    if (press) state_d = LIVE;
            default: state_d = LIVE;
        endcase
    end

    // The load decision uses the pre-press state, so a press on a boundary still takes one last snapshot.
    always_comb begin
        load    = bound && (state_q == LIVE);
        snap_d  = load ? probe : snap_q;
        frame_d = load;
        nxt     = load ? probe : snap_q;
        case (sel_s_q)
            2'd0:    bugout_d = nxt[3:0];
            2'd1:    bugout_d = nxt[7:4];
            2'd2:    bugout_d = nxt[11:8];
            default: bugout_d = nxt[15:12];
        endcase
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            sel_m_q  <= 2'b00;
            sel_s_q  <= 2'b00;
            sel_p_q  <= 2'b00;
            btn_m_q  <= 1'b0;
            btn_s_q  <= 1'b0;
            stable_q <= 1'b0;
            dcnt_q   <= '0;
            state_q  <= LIVE;
            snap_q   <= 16'h0000;
            frame_q  <= 1'b0;
            bugout_q <= 4'h0;
        end else begin
            sel_m_q  <= sel_m_d;
            sel_s_q  <= sel_s_d;
            sel_p_q  <= sel_p_d;
            btn_m_q  <= btn_m_d;
            btn_s_q  <= btn_s_d;
            stable_q <= stable_d;
            dcnt_q   <= dcnt_d;
            state_q  <= state_d;
            snap_q   <= snap_d;
            frame_q  <= frame_d;
            bugout_q <= bugout_d;
        end
    end

    assign bugout = bugout_q;
    assign frozen = (state_q == HELD);
    assign frame  = frame_q;

endmodule

// File: doc/bug_probe.md
# bug_probe

Target-side debug probe feeding the 4-wire serialized debug link. Captures a 16-bit probe word from the design under test, holds it as a coherent snapshot for one full display frame, and returns the nybble selected by the debug board's 2-bit digit select. A debounced button freezes the snapshot for inspection. It sits directly upstream of the debug board's seven-segment decoder: its `bugout` drives the board's `bugin`, and the board's `bugsel` drives its `bugsel`.

## Interface
- `DEB_BITS`, 16, width of the button debounce counter. Stable time is 2^DEB_BITS − 1 cycles, about 1.3 ms at 50 MHz.
- `mclk`  in  1  target clock, 50 MHz nominal, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low. Deassertion is synchronous to `mclk` (external).
- `probe`  in  16  live debug word from the target, synchronous to `mclk`.
- `bugsel`  in  2  digit select from the debug board. Asynchronous to `mclk`; changes roughly every 20 µs.
- `freeze_btn`  in  1  raw pushbutton, asynchronous, active-high, bouncy.
- `bugout`  out  4  selected nybble to the debug board, registered.
- `frozen`  out  1  high while the snapshot is frozen, registered.
- `frame`  out  1  one-cycle pulse on each snapshot load, registered.

## Operation
- **Select synchronizer**
  - `bugsel` passes through two flops to give `sel_s`.
  - A third flop holds `sel_p`, the previous value of `sel_s`.
  - Reset value of all three is 2'b00.
- **Frame boundary**
  - `bound` = (`sel_s` == 2'b00) && (`sel_p` != 2'b00).
  - Any nonzero→00 transition counts, including an out-of-order jump such as 01→00.
  - Holding `sel_s` at 00 produces only one boundary.
- **Snapshot register `snap[15:0]`**
  - Reset value 0.
  - On `bound` && !`frozen`: `snap` <= `probe` and `frame` <= 1.
  - Otherwise `snap` holds and `frame` <= 0.
- **Nybble select**
  - Each cycle, `bugout` <= `nxt[4*sel_s +: 4]`.
  - `nxt` is `probe` on a load cycle, else `snap` (load bypass).
  - Mapping: sel 0 → bits 3:0 (rightmost digit), 1 → 7:4, 2 → 11:8, 3 → 15:12.
- **Freeze button debounce**
  - `freeze_btn` passes through a two-flop sync to give `btn_s`.
  - `stable` is the debounced level; reset value 0.
  - Counter `dcnt[DEB_BITS-1:0]`:
    - Clears when `btn_s` == `stable`.
    - Increments when they differ.
    - On reaching all-ones: `stable` <= `btn_s` and `dcnt` <= 0.
  - A 0→1 transition of `stable` toggles `frozen`. Release (1→0) has no effect.
- **Freeze state**
  - Two states: LIVE (`frozen`=0, reset state) and HELD (`frozen`=1).
  - LIVE→HELD and HELD→LIVE occur only on a debounced press.
  - In HELD, `bugout` keeps cycling through the held `snap`; `frame` stays 0.
- **Freeze during a boundary**
  - If the debounced press and `bound` occur in the same cycle, the load uses the old `frozen` value.
  - So LIVE + `bound` loads one last snapshot while entering HELD.
- **Reset mid-operation**
  - All state returns to reset values immediately (asynchronous).
  - `bugout` = 0, `frozen` = 0, `frame` = 0, `snap` = 0, `stable` = 0, `dcnt` = 0.

## Timing
- `bugsel` edge to `bugout` update: 3 `mclk` cycles (2 sync + 1 output register).
  - The debug board samples `bugout` one full `bugsel` period later, so this latency is invisible.
- `bugsel`→00 edge to `frame` pulse: 3 cycles. `probe` is sampled on the same edge that raises `frame`.
- All four digits of one frame come from a single `probe` sample: the snapshot changes only at sel 00 entry.
- Button press to `frozen` toggle: 2 sync cycles + 2^DEB_BITS − 1 stable cycles + 1 cycle.
  - Any bounce shorter than the stable time restarts the count.
- No combinational path from any input to any output.

## Test plan
- Reset release, `probe`=16'hBEEF, then `bugsel` cycles 0,1,2,3,0 at 1000-cycle spacing → first `frame` 3 cycles after 3→0.
  - From then on, `bugout` = F,E,E,B for sel 0..3. Before that load, `bugout` = 0.
- `probe` changes to 16'h1234 while sel=2 → `bugout` stays at the BEEF nybbles until the next 00 entry, then shows 4,3,2,1.
- Set `DEB_BITS`=4. Press `freeze_btn` with 3 bounces of 5 cycles, then hold 30 cycles → `frozen`=1 exactly 2+15+1 cycles after the last bounce.
  - Subsequent `probe` changes are not loaded and `frame` stays 0.
- Second clean press → `frozen`=0. The next 00 entry loads the current `probe` and pulses `frame`.
- Debounced press coincides with `bound` → `snap` loads and `frame`=1 in the same cycle `frozen` rises. No further loads follow.
- Assert `rst_n`=0 while `frozen`=1 and sel=3 → asynchronously `bugout`=0, `frozen`=0, `frame`=0.
  - After release, the next 00 entry loads normally.
